// File: rtl/step_motor_sequencer_if.sv
// Command and status bundle for the stepper sequencer. The master drives the
// move request and parameters; the slave (the sequencer) returns coil drives
// and move status.
interface step_motor_sequencer_if #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 16
);
    logic                start;
    logic                stop;
    logic                dir;
    logic                half_step;
    logic [PERIOD_W-1:0] period;
    logic [COUNT_W-1:0]  steps;
    logic                hold_en;
    logic                AX;
    logic                AY;
    logic                BX;
    logic                BY;
    logic                busy;
    logic                done;
    logic                aborted;
    logic [COUNT_W-1:0]  position;

    modport master (
        output start, stop, dir, half_step, period, steps, hold_en,
        input  AX, AY, BX, BY, busy, done, aborted, position
    );

    modport slave (
        input  start, stop, dir, half_step, period, steps, hold_en,
        output AX, AY, BX, BY, busy, done, aborted, position
    );
endinterface

// File: rtl/step_motor_sequencer.sv
// Stepper motor phase sequencer. A start in IDLE latches direction, step mode,
// step period and step count, then issues one step every 'period' clocks
// until the count runs out or stop is seen. The 3-bit phase index walks an
// eight-entry half-step table; full-step mode snaps to the two-phase-on
// (odd) entries. Coil drives are registered and follow the index one clock
// later.
module step_motor_sequencer #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 16
) (
    input  logic                   csi_MCLK_clk,
    input  logic                   rsi_MRST_reset_n,
    step_motor_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          index;
    logic [2:0]          index_nxt;
    logic [2:0]          index_delta;
    logic [COUNT_W-1:0]  pos;
    logic [COUNT_W-1:0]  remaining;
    logic [PERIOD_W-1:0] div_cnt;
    logic [PERIOD_W-1:0] period_m1;
    logic                dir_q;
    logic                half_q;
    logic                aborted_q;
    logic [3:0]          coil_q;
    logic                accept;
    logic                step_tick;
    logic                last_step;

    // Phase table, {AX,AY,BX,BY}; odd entries are the two-phase-on positions.
    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1010;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b0101;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    assign accept    = (state == IDLE) && bus.start && !bus.stop;
    assign step_tick = (state == RUN) && (div_cnt == period_m1);
    assign last_step = step_tick && (remaining == COUNT_W'(1));

    // Index advance: +-1 in half-step, or onto the next odd entry in full-step.
    always_comb begin
        index_delta = 3'd1;
        if (!half_q && index[0]) begin
            index_delta = 3'd2;
        end
        index_nxt = dir_q ? (index + index_delta) : (index - index_delta);
    end

    // State register.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a zero-length move goes straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (bus.steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.stop || last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Move datapath: parameter capture, period divider, index/position/count.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            period_m1 <= '0;
            remaining <= '0;
            div_cnt   <= '0;
            index     <= 3'd0;
            pos       <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (accept) begin
                dir_q     <= bus.dir;
                half_q    <= bus.half_step;
                period_m1 <= (bus.period == '0) ? '0 : (bus.period - PERIOD_W'(1));
                remaining <= bus.steps;
                div_cnt   <= '0;
                aborted_q <= 1'b0;
            end
            if (state == RUN) begin
                if (step_tick) begin
                    div_cnt   <= '0;
                    index     <= index_nxt;
                    pos       <= dir_q ? (pos + COUNT_W'(1)) : (pos - COUNT_W'(1));
                    remaining <= remaining - COUNT_W'(1);
                end else begin
                    div_cnt <= div_cnt + PERIOD_W'(1);
                end
                if (bus.stop && !last_step) begin
                    aborted_q <= 1'b1;
                end
            end
        end
    end

    // Registered coil drives; de-energised in IDLE unless holding is enabled.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            coil_q <= 4'b0000;
        end else if ((state == IDLE) && !bus.hold_en) begin
            coil_q <= 4'b0000;
        end else begin
            coil_q <= phase_pattern(index);
        end
    end

    assign bus.AX       = coil_q[3];
    assign bus.AY       = coil_q[2];
    assign bus.BX       = coil_q[1];
    assign bus.BY       = coil_q[0];
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.aborted  = aborted_q;
    assign bus.position = pos;

endmodule

// File: doc/step_motor_sequencer.md
STEP_MOTOR_SEQUENCER -- requirements
Module: step_motor_sequencer

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16, meaning width of the step-period field.
REQ-002 SHALL have parameter COUNT_W, default 16, meaning width of the step-count field and of the position counter.
REQ-003 SHALL have port csi_MCLK_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rsi_MRST_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle move request.
REQ-006 SHALL have port stop, input, 1 bit: single-cycle abort request.
REQ-007 SHALL have port dir, input, 1 bit: 1 = forward (index increments), 0 = reverse; sampled at start.
REQ-008 SHALL have port half_step, input, 1 bit: 1 = half-step mode, 0 = full-step (two-phase-on) mode; sampled at start.
REQ-009 SHALL have port period, input, PERIOD_W bits: clock cycles per step; sampled at start.
REQ-010 SHALL have port steps, input, COUNT_W bits: number of steps to issue; sampled at start.
REQ-011 SHALL have port hold_en, input, 1 bit: keep the coils energized while idle; live, not sampled.
REQ-012 SHALL have ports AX, AY, BX, BY, output, 1 bit each: registered coil phase drives.
REQ-013 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 SHALL have port done, output, 1 bit: single-cycle pulse when a move ends.
REQ-015 SHALL have port aborted, output, 1 bit: set when a move ends by stop; cleared at the next accepted start.
REQ-016 SHALL have port position, output, COUNT_W bits: signed step position counter.

Function
REQ-017 SHALL keep a 3-bit phase index mapped to {AX,AY,BX,BY}: 0=1000, 1=1010, 2=0010, 3=0110, 4=0100, 5=0101, 6=0001, 7=1001.
REQ-018 SHALL implement states IDLE, RUN and DONE.
REQ-019 SHALL accept start only in IDLE; start in RUN or DONE SHALL be ignored.
REQ-020 In IDLE, start with stop low SHALL latch dir, half_step, period and steps, clear aborted, and move to RUN; if steps=0 it SHALL go to DONE instead, with no motion.
REQ-021 SHALL treat period=0 as period=1.
REQ-022 In RUN, a divider SHALL count period cycles; the first step SHALL occur exactly period cycles after the start cycle, and every later step period cycles after the previous one.
REQ-023 On each step in half-step mode, the index SHALL change by ±1.
REQ-024 On each step in full-step mode, the index SHALL change by ±2 if odd, or by ±1 if even (aligning to two-phase-on); ± follows dir.
REQ-025 The index SHALL wrap modulo 8 in both directions.
REQ-026 Each step SHALL update position by +1 (forward) or −1 (reverse) with two's-complement wrap, and SHALL decrement the remaining count.
REQ-027 When the remaining count reaches 0 on a step, the FSM SHALL go to DONE in the next cycle.
REQ-028 stop in RUN SHALL go to DONE in the next cycle without issuing a further step, and SHALL set aborted; if stop coincides with a step, the step SHALL still be issued.
REQ-029 stop in IDLE or DONE SHALL have no effect; start together with stop in IDLE SHALL be ignored.
REQ-030 DONE SHALL last one cycle, assert done, then go to IDLE.
REQ-031 In RUN and DONE, the phase outputs SHALL equal the table entry for the index.
REQ-032 In IDLE, the phase outputs SHALL equal the table entry if hold_en=1, else 0000.
REQ-033 Phase outputs SHALL reflect a new index one cycle after the step (registered).
REQ-034 busy SHALL be high exactly in RUN.

Reset
REQ-035 Reset low SHALL immediately force state IDLE, index 0, position 0, remaining count 0, divider 0, AX=AY=BX=BY=0, busy=0, done=0 and aborted=0, including mid-move.
REQ-036 After reset release, the first start SHALL be accepted in the first clock with rsi_MRST_reset_n high.

Verification
REQ-037 Half-step forward: dir=1, half_step=1, period=4, steps=8, hold_en=1 -> steps at cycles 4,8,...,32 after start; phases step through indices 1..7 then 0; position=8; done pulses once; aborted=0.
REQ-038 Full-step reverse from index 0: dir=0, half_step=0, period=2, steps=3 -> index 7, 5, 3; position=−3 (0xFFFD).
REQ-039 Abort: period=10, steps=100, stop asserted 25 cycles after start -> exactly 2 steps issued, done one cycle later, aborted=1, busy low.
REQ-040 Edge values: steps=0 -> done pulse in the next cycle with no phase change. Separately, period=0 -> one step per clock.
REQ-041 Idle hold: with hold_en=0 in IDLE, outputs are 0000; toggling hold_en to 1 restores the index pattern one cycle later. A start during RUN is ignored.
REQ-042 Reset mid-move: assert rsi_MRST_reset_n low in RUN -> all outputs 0 without waiting for a clock edge; after release, the FSM is in IDLE and position is 0.
